// File: rtl/m_pingpong_ctrl.sv
// m_pingpong_ctrl
// Ping-pong buffer controller between conv layer 1 and the 2x2 pooler.
// The write side turns the conv output strobe into buffer write addresses
// and fills two banks of two output rows each. The read side walks a full
// bank in 2x2-window order for the pooler and then hands the bank back.
// Frame completion is reported once every conv output of the frame has
// been written.

module m_pingpong_ctrl #(
   parameter int ROW_LEN   = 26,
   parameter int BANK_SIZE = 52,
   parameter int FRAME_OUT = 676,
   parameter int ADDR_W    = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wr_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [1:0]        bank_full,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_last,
   output logic              write_complete,
   output logic              overflow
);

   localparam int WCNT_W = $clog2(BANK_SIZE);
   localparam int FCNT_W = $clog2(FRAME_OUT + 1);
   localparam int WC_W   = $clog2(ROW_LEN / 2);

   localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(BANK_SIZE - 1);
   localparam logic [FCNT_W-1:0] FCNT_MAX   = FCNT_W'(FRAME_OUT);
   localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(FRAME_OUT - 1);
   localparam logic [WC_W-1:0]   WC_LAST    = WC_W'(ROW_LEN / 2 - 1);
   localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BANK_SIZE);
   localparam logic [ADDR_W-1:0] ROW_OFF    = ADDR_W'(ROW_LEN);

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_BANK = 1'b1
   } rd_state_t;

   // write-side state
   logic [WCNT_W-1:0] wcnt;
   logic              wb;
   logic [FCNT_W-1:0] fcnt;
   logic              wr_last;
   logic              wr_bank;

   // read-side state
   rd_state_t         state;
   rd_state_t         state_n;
   logic              rb;
   logic              rb_n;
   logic [WC_W-1:0]   wc;
   logic [WC_W-1:0]   wc_n;
   logic [1:0]        p;
   logic [1:0]        p_n;
   logic [ADDR_W-1:0] rd_addr_n;
   logic              rd_last_n;

   // shared bookkeeping
   logic              frame_open;
   logic              wr_fire;
   logic              wr_drop;
   logic [ADDR_W-1:0] wr_addr_n;
   logic              rd_done;
   logic [1:0]        bank_full_n;

   // A strobe only counts while the frame is running and not yet complete;
   // strobes after the last output of the frame are silently ignored.
   assign frame_open = start && wr_valid && (fcnt < FCNT_MAX);
   assign wr_fire    = frame_open && !bank_full[wb];
   assign wr_drop    = frame_open && bank_full[wb];
   assign wr_addr_n  = (wb ? BANK1_BASE : '0) + ADDR_W'(wcnt);

   // The final window of the bank is handed over to the pooler this cycle.
   assign rd_done = (state == RD_BANK) && rd_ready && (wc == WC_LAST) && (p == 2'd3);

   // Bank ownership: a bank is marked full one cycle after its last write is
   // presented, and released one cycle after its last read is accepted.
   // Both updates can land together on different banks.
   always_comb begin
      bank_full_n = bank_full;
      if (wr_en && wr_last) begin
         bank_full_n[wr_bank] = 1'b1;
      end
      if (rd_done) begin
         bank_full_n[rb] = 1'b0;
      end
   end

   // Write addressing, frame counting, completion and overflow flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt           <= '0;
         wb             <= 1'b0;
         fcnt           <= '0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_last        <= 1'b0;
         wr_bank        <= 1'b0;
         bank_full      <= 2'b00;
         write_complete <= 1'b0;
         overflow       <= 1'b0;
      end else if (!start) begin
         wcnt           <= '0;
         wb             <= 1'b0;
         fcnt           <= '0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_last        <= 1'b0;
         wr_bank        <= 1'b0;
         bank_full      <= 2'b00;
         write_complete <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         wr_en     <= wr_fire;
         wr_last   <= wr_fire && (wcnt == WCNT_LAST);
         bank_full <= bank_full_n;
         if (wr_fire) begin
            wr_addr <= wr_addr_n;
            wr_bank <= wb;
            fcnt    <= fcnt + 1'b1;
            if (wcnt == WCNT_LAST) begin
               wcnt <= '0;
               wb   <= ~wb;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
            if (fcnt == FCNT_LAST) begin
               write_complete <= 1'b1;
            end
         end
         if (wr_drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Read FSM next state: walk windows left to right, each window as
   // top-left, top-right, bottom-left, bottom-right, then return to idle
   // for one cycle before the next bank. The next read address is computed
   // here so that rd_addr can be driven straight from a register.
   always_comb begin
      state_n   = state;
      rb_n      = rb;
      wc_n      = wc;
      p_n       = p;
      rd_addr_n = '0;
      rd_last_n = 1'b0;
      case (state)
         RD_IDLE: begin
            if (bank_full[rb]) begin
               state_n = RD_BANK;
               wc_n    = '0;
               p_n     = 2'd0;
            end
         end
         RD_BANK: begin
            if (rd_ready) begin
               if (p == 2'd3) begin
                  p_n = 2'd0;
                  if (wc == WC_LAST) begin
                     state_n = RD_IDLE;
                     rb_n    = ~rb;
                     wc_n    = '0;
                  end else begin
                     wc_n = wc + 1'b1;
                  end
               end else begin
                  p_n = p + 2'd1;
               end
            end
         end
         default: begin
            state_n = RD_IDLE;
         end
      endcase
      rd_addr_n = (rb_n ? BANK1_BASE : '0) + ADDR_W'({wc_n, 1'b0}) + ADDR_W'(p_n[0])
                  + (p_n[1] ? ROW_OFF : '0);
      rd_last_n = (state_n == RD_BANK) && (wc_n == WC_LAST) && (p_n == 2'd3);
   end

   // Read FSM state register and registered pooler-facing outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RD_IDLE;
         rb       <= 1'b0;
         wc       <= '0;
         p        <= 2'd0;
         rd_valid <= 1'b0;
         rd_addr  <= '0;
         rd_last  <= 1'b0;
      end else if (!start) begin
         state    <= RD_IDLE;
         rb       <= 1'b0;
         wc       <= '0;
         p        <= 2'd0;
         rd_valid <= 1'b0;
         rd_addr  <= '0;
         rd_last  <= 1'b0;
      end else begin
         state    <= state_n;
         rb       <= rb_n;
         wc       <= wc_n;
         p        <= p_n;
         rd_valid <= (state_n == RD_BANK);
         rd_addr  <= rd_addr_n;
         rd_last  <= rd_last_n;
      end
   end

endmodule

// File: tb/tb_m_pingpong_ctrl.sv
// tb_m_pingpong_ctrl
// Directed bench for the ping-pong buffer controller: reset state, read
// order, backpressure, overflow, simultaneous set/clear, a full frame with
// the conv strobe pattern, and mid-frame reset / clear.

module tb_m_pingpong_ctrl;

   localparam int ADDR_W = 7;

   logic              clk;
   logic              rst;
   logic              start;
   logic              wr_valid;
   logic              rd_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        bank_full;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_last;
   logic              write_complete;
   logic              overflow;

   int errors = 0;
   int checks = 0;

   m_pingpong_ctrl #(
      .ROW_LEN  (26),
      .BANK_SIZE(52),
      .FRAME_OUT(676),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .wr_valid      (wr_valid),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .bank_full     (bank_full),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_addr       (rd_addr),
      .rd_last       (rd_last),
      .write_complete(write_complete),
      .overflow      (overflow)
   );

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // hard stop in case anything stalls
   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic rr);
      wr_valid = wv;
      rd_ready = rr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearFrame();
      start = 1'b0;
      applyStimulus(1'b0, 1'b0);
      tick();
      start = 1'b1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_wr_en"},          wr_en,          0);
      checkOutput({tag, "_wr_addr"},        wr_addr,        0);
      checkOutput({tag, "_bank_full"},      bank_full,      0);
      checkOutput({tag, "_rd_valid"},       rd_valid,       0);
      checkOutput({tag, "_rd_addr"},        rd_addr,        0);
      checkOutput({tag, "_rd_last"},        rd_last,        0);
      checkOutput({tag, "_write_complete"}, write_complete, 0);
      checkOutput({tag, "_overflow"},       overflow,       0);
   endtask

   // 2x2 window order inside a bank: TL, TR, BL, BR, then next window
   function automatic int orderOffset(input int i);
      int wcol;
      int ph;
      wcol = i / 4;
      ph   = i % 4;
      return 2 * wcol + (ph % 2) + (ph / 2) * 26;
   endfunction

   // conv strobe: 26 active cycles out of every 28
   function automatic logic convValid(input int k);
      return ((k - 1) % 28) < 26;
   endfunction

   initial begin
      int   wr_seen;
      int   rd_seen;
      int   last_wr;
      int   first_rd;
      int   bf_rise;
      int   bf_fall;
      int   done_k;
      int   errs;
      int   n;
      int   vcount;
      int   last_n;
      int   gaps;
      int   drains;
      int   wcount;
      logic ready;
      logic prev_stall;
      logic [ADDR_W-1:0] prev_addr;
      logic [ADDR_W-1:0] rd_log [0:51];

      // ---------------- reset state ----------------
      rst   = 1'b1;
      start = 1'b0;
      applyStimulus(1'b0, 1'b0);
      #1 rst = 1'b0;
      #1;
      checkResetOutputs("reset");
      tick();
      tick();
      rst   = 1'b1;
      start = 1'b1;

      // ---------------- read order, bank 0 ----------------
      wr_seen = 0; rd_seen = 0; last_wr = -1; first_rd = -1;
      bf_rise = -1; bf_fall = -1; done_k = -1;
      for (int k = 1; k <= 130; k++) begin
         tick();
         if (wr_en) begin
            checkOutput("order_wr_addr", wr_addr, wr_seen);
            wr_seen++;
            last_wr = k;
         end
         if (bank_full[0] && bf_rise < 0) bf_rise = k;
         if (!bank_full[0] && bf_rise >= 0 && bf_fall < 0) bf_fall = k;
         applyStimulus(k <= 52, 1'b1);
         if (rd_valid) begin
            if (first_rd < 0) first_rd = k;
            if (rd_seen < 52) begin
               rd_log[rd_seen] = rd_addr;
               checkOutput("order_rd_last", rd_last, rd_seen == 51);
               if (rd_last) done_k = k;
            end
            rd_seen++;
         end
      end
      checkOutput("order_wr_count", wr_seen, 52);
      checkOutput("order_rd_count", rd_seen, 52);
      checkOutput("order_full_rise", bf_rise, last_wr + 1);
      checkOutput("order_first_rd_latency", first_rd - last_wr, 2);
      checkOutput("order_full_fall", bf_fall, done_k + 1);
      checkOutput("order_addr0", rd_log[0], 0);
      checkOutput("order_addr1", rd_log[1], 1);
      checkOutput("order_addr2", rd_log[2], 26);
      checkOutput("order_addr3", rd_log[3], 27);
      checkOutput("order_addr4", rd_log[4], 2);
      checkOutput("order_addr5", rd_log[5], 3);
      checkOutput("order_addr6", rd_log[6], 28);
      checkOutput("order_addr7", rd_log[7], 29);
      checkOutput("order_addr48", rd_log[48], 24);
      checkOutput("order_addr49", rd_log[49], 25);
      checkOutput("order_addr50", rd_log[50], 50);
      checkOutput("order_addr51", rd_log[51], 51);
      errs = 0;
      for (int i = 0; i < 52; i++) begin
         if (rd_log[i] !== ADDR_W'(orderOffset(i))) errs++;
      end
      checkOutput("order_seq_errs", errs, 0);

      // ---------------- backpressure, bank 1 ----------------
      wr_seen = 0; vcount = 0; n = 0; errs = 0; last_n = -1;
      prev_stall = 1'b0; prev_addr = '0;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (wr_en) begin
            checkOutput("bp_wr_addr", wr_addr, 52 + wr_seen);
            wr_seen++;
         end
         ready = 1'b0;
         if (rd_valid) begin
            vcount++;
            if (prev_stall) checkOutput("bp_hold", rd_addr, prev_addr);
            ready = (vcount % 2 == 0);
            if (ready) begin
               if (rd_addr !== ADDR_W'(52 + orderOffset(n))) errs++;
               if (rd_last) last_n = n;
               n++;
            end else begin
               prev_addr = rd_addr;
            end
            prev_stall = !ready;
         end else begin
            prev_stall = 1'b0;
         end
         applyStimulus(k <= 52, ready);
      end
      checkOutput("bp_valid_cycles", vcount, 104);
      checkOutput("bp_transfers", n, 52);
      checkOutput("bp_addr_errs", errs, 0);
      checkOutput("bp_last_index", last_n, 51);
      checkOutput("bp_bank_full", bank_full, 0);

      // ---------------- overflow ----------------
      clearFrame();
      wcount = 0;
      for (int k = 1; k <= 130; k++) begin
         tick();
         if (wr_en) wcount++;
         if (k == 105) checkOutput("ovf_before", overflow, 0);
         if (k == 106) checkOutput("ovf_after", overflow, 1);
         applyStimulus(k <= 105, 1'b0);
      end
      checkOutput("ovf_wr_count", wcount, 104);
      checkOutput("ovf_bank_full", bank_full, 2'b11);
      checkOutput("ovf_sticky", overflow, 1);
      checkOutput("ovf_rd_valid", rd_valid, 1);
      checkOutput("ovf_first_rd_addr", rd_addr, 0);
      n = 0; errs = 0; gaps = 0;
      for (int k = 1; k <= 150; k++) begin
         tick();
         applyStimulus(1'b0, 1'b1);
         if (rd_valid) begin
            if (n < 52) begin
               if (rd_addr !== ADDR_W'(orderOffset(n))) errs++;
            end else begin
               if (rd_addr !== ADDR_W'(52 + orderOffset(n - 52))) errs++;
            end
            n++;
         end else if (n > 0 && n < 104) begin
            gaps++;
         end
      end
      checkOutput("ovf_drain_count", n, 104);
      checkOutput("ovf_drain_errs", errs, 0);
      checkOutput("ovf_idle_gap", gaps, 1);
      checkOutput("ovf_drained_full", bank_full, 0);

      // ---------------- simultaneous set / clear ----------------
      clearFrame();
      checkOutput("clr_overflow", overflow, 0);
      for (int k = 1; k <= 170; k++) begin
         tick();
         if (k == 106) begin
            checkOutput("sim_rd_last", rd_last, 1);
            checkOutput("sim_wr_en", wr_en, 1);
            checkOutput("sim_wr_addr", wr_addr, 103);
         end
         if (k == 107) begin
            checkOutput("sim_bank_full", bank_full, 2'b10);
            checkOutput("sim_idle", rd_valid, 0);
         end
         if (k == 108) begin
            checkOutput("sim_rd_valid", rd_valid, 1);
            checkOutput("sim_rd_addr", rd_addr, 52);
         end
         applyStimulus((k <= 52) || (k >= 54 && k <= 105), 1'b1);
      end
      checkOutput("sim_final_full", bank_full, 0);

      // ---------------- full frame, conv pattern ----------------
      clearFrame();
      wcount = 0; errs = 0; drains = 0;
      for (int k = 1; k <= 900; k++) begin
         tick();
         if (wr_en) begin
            if (wr_addr !== ADDR_W'(wcount % 104)) errs++;
            wcount++;
            if (wcount == 675) checkOutput("frame_complete_early", write_complete, 0);
            if (wcount == 676) checkOutput("frame_complete_rise", write_complete, 1);
         end
         if (rd_valid && rd_last) drains++;
         applyStimulus(convValid(k), 1'b1);
      end
      checkOutput("frame_wr_count", wcount, 676);
      checkOutput("frame_addr_errs", errs, 0);
      checkOutput("frame_drains", drains, 13);
      checkOutput("frame_complete", write_complete, 1);
      checkOutput("frame_overflow", overflow, 0);
      checkOutput("frame_bank_full", bank_full, 0);

      // ---------------- async reset mid-frame ----------------
      clearFrame();
      wcount = 0;
      for (int k = 1; k <= 400; k++) begin
         tick();
         if (wr_en) wcount++;
         if (wcount == 300) break;
         applyStimulus(convValid(k), 1'b1);
      end
      checkOutput("rst_reach", wcount, 300);
      #2 rst = 1'b0;
      #1;
      checkResetOutputs("async_rst");
      applyStimulus(1'b0, 1'b0);
      tick();
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1);
      tick();
      checkOutput("rst_next_wr_en", wr_en, 1);
      checkOutput("rst_next_wr_addr", wr_addr, 0);
      applyStimulus(1'b0, 1'b1);

      // ---------------- start low mid-frame ----------------
      clearFrame();
      wcount = 0;
      for (int k = 1; k <= 400; k++) begin
         tick();
         if (wr_en) wcount++;
         if (wcount == 300) break;
         applyStimulus(convValid(k), 1'b1);
      end
      checkOutput("clr_reach", wcount, 300);
      start = 1'b0;
      applyStimulus(1'b0, 1'b0);
      tick();
      checkResetOutputs("sync_clr");
      start = 1'b1;
      applyStimulus(1'b1, 1'b1);
      tick();
      checkOutput("clr_next_wr_en", wr_en, 1);
      checkOutput("clr_next_wr_addr", wr_addr, 0);
      applyStimulus(1'b0, 1'b0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
